// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared constants, defaults and loader state type for the mini CNN PE path
package cnn_pkg;

    localparam int DEF_WIN_SIZE = 9;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_OUT_W    = 32;

    localparam logic [1:0] MODE_RELU    = 2'b00;
    localparam logic [1:0] MODE_MAXPOOL = 2'b01;
    localparam logic [1:0] MODE_RAW     = 2'b10;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LOAD,
        LD_GAP,
        LD_WAIT,
        LD_RESP
    } loader_state_t;

endpackage

// File: rtl/mini_cnn_pe_loader_if.sv
// rtl/mini_cnn_pe_loader_if.sv - request, PE load port and response signals of the PE loader
//
// Groups:
//   req_*  : window request in (valid/ready), pixels/kernel packed k at [k*DATA_W +: DATA_W]
//   pe_*   : serial load port towards one mini_cnn_pe (data/start/mode out, done/result in)
//   rsp_*  : result response out (valid/ready), rsp_err flags a PE timeout
// Modports: slave = the loader, master = host plus PE side.
interface mini_cnn_pe_loader_if
    import cnn_pkg::*;
#(
    parameter int WIN_SIZE = DEF_WIN_SIZE,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int OUT_W    = DEF_OUT_W
) ();

    logic                       req_valid;
    logic                       req_ready;
    logic [WIN_SIZE*DATA_W-1:0] req_pixels;
    logic [WIN_SIZE*DATA_W-1:0] req_kernel;
    logic [1:0]                 req_mode;

    logic [DATA_W-1:0]          pe_data;
    logic                       pe_start;
    logic [1:0]                 pe_mode;
    logic                       pe_done;
    logic [OUT_W-1:0]           pe_result;

    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [OUT_W-1:0]           rsp_result;
    logic                       rsp_err;

    modport slave (
        input  req_valid, req_pixels, req_kernel, req_mode,
        output req_ready,
        output pe_data, pe_start, pe_mode,
        input  pe_done, pe_result,
        output rsp_valid, rsp_result, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_pixels, req_kernel, req_mode,
        input  req_ready,
        input  pe_data, pe_start, pe_mode,
        output pe_done, pe_result,
        input  rsp_valid, rsp_result, rsp_err,
        output rsp_ready
    );

endinterface

// File: rtl/mini_cnn_pe_loader.sv
// rtl/mini_cnn_pe_loader.sv - streams one window request into mini_cnn_pe and returns its result
//
// Ports:
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mini_cnn_pe_loader_if.slave (request in, PE load port, response out)
// All bus outputs are registered. One job at a time: IDLE -> LOAD -> GAP -> WAIT -> RESP.
module mini_cnn_pe_loader
    import cnn_pkg::*;
#(
    parameter int WIN_SIZE = DEF_WIN_SIZE,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int TIMEOUT  = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    mini_cnn_pe_loader_if.slave  bus
);

    localparam int NBYTES = 2 * WIN_SIZE;
    localparam int IDX_W  = $clog2(NBYTES);
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    loader_state_t              state_q;
    logic [NBYTES*DATA_W-1:0]   bytes_q;     // {kernel, pixels}: byte k at [k*DATA_W +: DATA_W]
    logic [IDX_W-1:0]           idx_q;       // index of the byte currently on pe_data
    logic [IDX_W-1:0]           idx_d;
    logic [CNT_W-1:0]           cnt_q;
    logic                       req_ready_q;
    logic                       pe_start_q;
    logic [DATA_W-1:0]          pe_data_q;
    logic [1:0]                 pe_mode_q;
    logic                       rsp_valid_q;
    logic [OUT_W-1:0]           rsp_result_q;
    logic                       rsp_err_q;

    assign idx_d = idx_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LD_IDLE;
            bytes_q      <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            req_ready_q  <= 1'b0;
            pe_start_q   <= 1'b0;
            pe_data_q    <= '0;
            pe_mode_q    <= MODE_RELU;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                LD_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (bus.req_valid && req_ready_q) begin
                        bytes_q     <= {bus.req_kernel, bus.req_pixels};
                        pe_mode_q   <= bus.req_mode;
                        idx_q       <= '0;
                        // The latch lands on this same edge, so byte 0 comes straight from the input.
                        pe_data_q   <= bus.req_pixels[DATA_W-1:0];
                        pe_start_q  <= 1'b1;
                        req_ready_q <= 1'b0;
                        state_q     <= LD_LOAD;
                    end
                end
                LD_LOAD: begin
                    if (idx_q == LAST_IDX) begin
                        pe_start_q <= 1'b0;
                        pe_data_q  <= '0;
                        state_q    <= LD_GAP;
                    end else begin
                        pe_data_q <= bytes_q[int'(idx_d)*DATA_W +: DATA_W];
                        idx_q     <= idx_d;
                    end
                end
                LD_GAP: begin
                    cnt_q   <= '0;
                    state_q <= LD_WAIT;
                end
                LD_WAIT: begin
                    // done is checked first so it wins over a coincident timeout.
                    if (bus.pe_done) begin
                        rsp_result_q <= bus.pe_result;
                        rsp_err_q    <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= LD_RESP;
                    end else if (cnt_q == TIMEOUT_CNT) begin
                        rsp_result_q <= '0;
                        rsp_err_q    <= 1'b1;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= LD_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                LD_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= LD_IDLE;
                    end
                end
                default: begin
                    state_q <= LD_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.pe_start   = pe_start_q;
    assign bus.pe_data    = pe_data_q;
    assign bus.pe_mode    = pe_mode_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_err    = rsp_err_q;

endmodule
